// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared AXI4-Lite response codes and scheduler states.
// Imported by the read/write scheduler and its round-robin arbiter.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } sched_state_t;

   localparam logic GRANT_RD = 1'b0;
   localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/axi4_lite_rr_arb2.sv
// axi4_lite_rr_arb2: two-requester (write/read) round-robin arbiter.
// Ports: clk, rst (sync, active-high), wr_req/rd_req in,
//   advance + served_write record the finished grant,
//   gnt_wr/gnt_rd combinational one-hot grant.
module axi4_lite_rr_arb2
   import axi4_lite_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic wr_req,
   input  logic rd_req,
   input  logic advance,
   input  logic served_write,
   output logic gnt_wr,
   output logic gnt_rd
);

   logic last_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= GRANT_RD;
      end else if (advance) begin
         last_grant <= served_write;
      end
   end

   // On a tie the side that was not served last wins.
   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      unique case (1'b1)
         (wr_req && !rd_req): gnt_wr = 1'b1;
         (rd_req && !wr_req): gnt_rd = 1'b1;
         (wr_req && rd_req): begin
            gnt_wr = (last_grant == GRANT_RD);
            gnt_rd = (last_grant == GRANT_WR);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/axi4_lite_rw_sched.sv
// axi4_lite_rw_sched: serializes AXI4-Lite write/read backend requests
// onto one register-file port with round-robin and a per-access timeout.
// Ports: ACLK/ARESET; wr_* and rd_* request/done strobe interfaces;
//   be_* single shared backend command/completion port.
module axi4_lite_rw_sched
   import axi4_lite_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic                      wr_req,
   input  logic [ADDRESS_WIDTH-1:0]  wr_addr,
   input  logic [DATA_WIDTH-1:0]     wr_wdata,
   input  logic [DATA_WIDTH/8-1:0]   wr_wstrb,
   output logic                      wr_done,
   output logic [1:0]                wr_resp,
   input  logic                      rd_req,
   input  logic [ADDRESS_WIDTH-1:0]  rd_addr,
   output logic                      rd_done,
   output logic [DATA_WIDTH-1:0]     rd_rdata,
   output logic [1:0]                rd_resp,
   output logic                      be_valid,
   input  logic                      be_ready,
   output logic                      be_write,
   output logic [ADDRESS_WIDTH-1:0]  be_addr,
   output logic [DATA_WIDTH-1:0]     be_wdata,
   output logic [DATA_WIDTH/8-1:0]   be_wstrb,
   input  logic                      be_done,
   input  logic [DATA_WIDTH-1:0]     be_rdata,
   input  logic [1:0]                be_resp
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   sched_state_t            state;
   sched_state_t            state_d;
   logic                    gnt_wr;
   logic                    gnt_rd;
   logic                    grant;
   logic                    capture;
   logic                    expire;
   logic                    cur_write;
   logic [CNT_W-1:0]        tmo_cnt;
   logic [CNT_W-1:0]        tmo_inc;
   logic                    tmo_hit;
   axi_resp_t               resp_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   axi4_lite_rr_arb2 u_arb (
      .clk          (ACLK),
      .rst          (ARESET),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .advance      (state == ST_DONE),
      .served_write (cur_write),
      .gnt_wr       (gnt_wr),
      .gnt_rd       (gnt_rd)
   );

   assign tmo_inc = tmo_cnt + CNT_W'(1);
   assign tmo_hit = (tmo_inc == TMO_LIMIT);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // A completion in the same cycle as the limit still wins over timeout.
   always_comb begin
      state_d = state;
      grant   = 1'b0;
      capture = 1'b0;
      expire  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (gnt_wr || gnt_rd) begin
               grant   = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (be_ready && be_done) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end else if (tmo_hit) begin
               expire  = 1'b1;
               state_d = ST_DONE;
            end else if (be_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (be_done) begin
               capture = 1'b1;
               state_d = ST_DONE;
            end else if (tmo_hit) begin
               expire  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cur_write <= 1'b0;
         be_addr   <= '0;
         be_wdata  <= '0;
         be_wstrb  <= '0;
         tmo_cnt   <= '0;
         resp_q    <= OKAY;
         rdata_q   <= '0;
      end else begin
         if (grant) begin
            cur_write <= gnt_wr;
            be_addr   <= gnt_wr ? wr_addr : rd_addr;
            be_wdata  <= gnt_wr ? wr_wdata : '0;
            be_wstrb  <= gnt_wr ? wr_wstrb : '0;
            tmo_cnt   <= '0;
         end else if (state == ST_ISSUE || state == ST_WAIT) begin
            tmo_cnt <= tmo_inc;
         end
         if (capture) begin
            resp_q  <= axi_resp_t'(be_resp);
            rdata_q <= cur_write ? '0 : be_rdata;
         end else if (expire) begin
            resp_q  <= SLVERR;
            rdata_q <= '0;
         end
      end
   end

   assign be_valid = (state == ST_ISSUE);
   assign be_write = cur_write;
   assign wr_done  = (state == ST_DONE) && cur_write;
   assign rd_done  = (state == ST_DONE) && !cur_write;
   assign wr_resp  = wr_done ? resp_q : OKAY;
   assign rd_resp  = rd_done ? resp_q : OKAY;
   assign rd_rdata = rd_done ? rdata_q : '0;

endmodule

// File: tb/tb_axi4_lite_rw_sched.sv
// tb_axi4_lite_rw_sched: scoreboard bench for axi4_lite_rw_sched.
// Directed vectors; completions and commands checked by monitors.
module tb_axi4_lite_rw_sched;
   import axi4_lite_pkg::*;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        wr_req = 1'b0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_wdata = '0;
   logic [3:0]  wr_wstrb = '0;
   logic        wr_done;
   logic [1:0]  wr_resp;
   logic        rd_req = 1'b0;
   logic [31:0] rd_addr = '0;
   logic        rd_done;
   logic [31:0] rd_rdata;
   logic [1:0]  rd_resp;
   logic        be_valid;
   logic        be_ready = 1'b0;
   logic        be_write;
   logic [31:0] be_addr;
   logic [31:0] be_wdata;
   logic [3:0]  be_wstrb;
   logic        be_done = 1'b0;
   logic [31:0] be_rdata = '0;
   logic [1:0]  be_resp = '0;

   axi4_lite_rw_sched #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
      .wr_wstrb(wr_wstrb), .wr_done(wr_done), .wr_resp(wr_resp),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done),
      .rd_rdata(rd_rdata), .rd_resp(rd_resp),
      .be_valid(be_valid), .be_ready(be_ready), .be_write(be_write),
      .be_addr(be_addr), .be_wdata(be_wdata), .be_wstrb(be_wstrb),
      .be_done(be_done), .be_rdata(be_rdata), .be_resp(be_resp)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic        wr;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } cpl_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } cmd_t;

   cpl_t exp_cpl[$];
   cmd_t exp_cmd[$];
   int   n_tests = 0;
   int   n_fail = 0;

   // backend model configuration
   bit          bk_auto = 1'b1;
   int          bk_rdy = 0;
   int          bk_dly = 0;
   logic [1:0]  bk_resp = OKAY;
   logic [31:0] bk_rdata = '0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // completion scoreboard
   initial begin
      cpl_t e;
      forever begin
         @(negedge ACLK);
         if (wr_done || rd_done) begin
            if (exp_cpl.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: wr_done=%0b rd_done=%0b",
                        wr_done, rd_done);
            end else begin
               e = exp_cpl.pop_front();
               chk("done_dir", 64'(wr_done), 64'(e.wr));
               chk("done_excl", 64'(rd_done), 64'(!e.wr));
               if (e.wr) begin
                  chk("wr_resp", 64'(wr_resp), 64'(e.resp));
               end else begin
                  chk("rd_resp", 64'(rd_resp), 64'(e.resp));
                  chk("rd_rdata", 64'(rd_rdata), 64'(e.rdata));
               end
            end
         end
      end
   end

   // backend responder and command checker
   initial begin
      bit   busy;
      int   cnt;
      cmd_t cur;
      busy = 1'b0;
      cnt = 0;
      cur = '0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            busy = 1'b0;
            be_ready = 1'b0;
            be_done = 1'b0;
         end else if (bk_auto) begin
            be_ready = 1'b0;
            be_done = 1'b0;
            if (!busy && be_valid) begin
               busy = 1'b1;
               cnt = 0;
               if (exp_cmd.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_cmd: addr %0h", be_addr);
               end else begin
                  cur = exp_cmd.pop_front();
               end
            end
            if (busy) begin
               chk("be_write", 64'(be_write), 64'(cur.wr));
               chk("be_addr", 64'(be_addr), 64'(cur.addr));
               if (cur.wr) begin
                  chk("be_wdata", 64'(be_wdata), 64'(cur.wdata));
                  chk("be_wstrb", 64'(be_wstrb), 64'(cur.wstrb));
               end
               if (cnt == bk_rdy && be_valid) be_ready = 1'b1;
               if (cnt == bk_dly) begin
                  be_done = 1'b1;
                  be_resp = bk_resp;
                  be_rdata = bk_rdata;
                  busy = 1'b0;
               end
               cnt++;
            end
         end
      end
   end

   // Run until both requests are retired; each requester drops its
   // level in the cycle after its done pulse.
   task automatic serve(input int max_cyc, output int wc, output int rc);
      bit wp;
      bit rp;
      wc = -1;
      rc = -1;
      wp = 1'b0;
      rp = 1'b0;
      for (int c = 1; c <= max_cyc; c++) begin
         if (!(wr_req || rd_req)) break;
         @(posedge ACLK);
         #1;
         if (wp) begin wr_req = 1'b0; wp = 1'b0; end
         if (rp) begin rd_req = 1'b0; rp = 1'b0; end
         if (wr_done) begin wc = c; wp = 1'b1; end
         if (rd_done) begin rc = c; rp = 1'b1; end
      end
      if (wr_req || rd_req) begin
         n_tests++;
         n_fail++;
         $display("FAIL serve_bound: wr_req=%0b rd_req=%0b still high",
                  wr_req, rd_req);
         wr_req = 1'b0;
         rd_req = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge ACLK);
      #1;
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_be_valid"}, 64'(be_valid), 64'(0));
      chk({tag, "_be_write"}, 64'(be_write), 64'(0));
      chk({tag, "_be_addr"}, 64'(be_addr), 64'(0));
      chk({tag, "_be_wdata"}, 64'(be_wdata), 64'(0));
      chk({tag, "_be_wstrb"}, 64'(be_wstrb), 64'(0));
      chk({tag, "_wr_done"}, 64'(wr_done), 64'(0));
      chk({tag, "_rd_done"}, 64'(rd_done), 64'(0));
      chk({tag, "_wr_resp"}, 64'(wr_resp), 64'(0));
      chk({tag, "_rd_resp"}, 64'(rd_resp), 64'(0));
      chk({tag, "_rd_rdata"}, 64'(rd_rdata), 64'(0));
   endtask

   function automatic cmd_t mk_cmd(logic w, logic [31:0] a,
                                   logic [31:0] d, logic [3:0] s);
      cmd_t c;
      c.wr = w;
      c.addr = a;
      c.wdata = d;
      c.wstrb = s;
      return c;
   endfunction

   function automatic cpl_t mk_cpl(logic w, logic [1:0] r, logic [31:0] d);
      cpl_t c;
      c.wr = w;
      c.resp = r;
      c.rdata = d;
      return c;
   endfunction

   initial begin
      int wc;
      int rc;

      // reset state
      repeat (2) @(posedge ACLK);
      #1;
      chk_zero("rst");
      ARESET = 1'b0;

      // single write, ready at 1, done at 3
      bk_rdy = 1; bk_dly = 3; bk_resp = OKAY; bk_rdata = 32'hCAFE0000;
      wr_addr = 32'h10; wr_wdata = 32'hDEADBEEF; wr_wstrb = 4'hF;
      exp_cmd.push_back(mk_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF));
      exp_cpl.push_back(mk_cpl(1'b1, OKAY, 32'h0));
      wr_req = 1'b1;
      serve(40, wc, rc);
      chk("t1_wr_cycle", 64'(wc), 64'(5));
      chk("t1_no_rd", 64'(rc), 64'(-1));

      // tie after reset: write, then read
      do_reset();
      bk_rdy = 0; bk_dly = 0; bk_resp = OKAY; bk_rdata = 32'h5555AAAA;
      wr_addr = 32'h100; wr_wdata = 32'h11111111; wr_wstrb = 4'h3;
      rd_addr = 32'h200;
      exp_cmd.push_back(mk_cmd(1'b1, 32'h100, 32'h11111111, 4'h3));
      exp_cmd.push_back(mk_cmd(1'b0, 32'h200, 32'h0, 4'h0));
      exp_cpl.push_back(mk_cpl(1'b1, OKAY, 32'h0));
      exp_cpl.push_back(mk_cpl(1'b0, OKAY, 32'h5555AAAA));
      wr_req = 1'b1;
      rd_req = 1'b1;
      serve(40, wc, rc);
      chk("t2_wr_first", 64'(wc), 64'(2));
      chk("t2_rd_second", 64'(rc), 64'(5));

      // lone write leaves last_grant = write
      wr_addr = 32'h104; wr_wdata = 32'h22; wr_wstrb = 4'h1;
      exp_cmd.push_back(mk_cmd(1'b1, 32'h104, 32'h22, 4'h1));
      exp_cpl.push_back(mk_cpl(1'b1, OKAY, 32'h0));
      wr_req = 1'b1;
      serve(40, wc, rc);
      chk("t2_lone_wr", 64'(wc), 64'(2));

      // tie again: read, then write
      wr_addr = 32'h108; wr_wdata = 32'h33333333; wr_wstrb = 4'hF;
      rd_addr = 32'h20C; bk_rdata = 32'h0000BEEF;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h20C, 32'h0, 4'h0));
      exp_cmd.push_back(mk_cmd(1'b1, 32'h108, 32'h33333333, 4'hF));
      exp_cpl.push_back(mk_cpl(1'b0, OKAY, 32'h0000BEEF));
      exp_cpl.push_back(mk_cpl(1'b1, OKAY, 32'h0));
      wr_req = 1'b1;
      rd_req = 1'b1;
      serve(40, wc, rc);
      chk("t2b_rd_first", 64'(rc), 64'(2));
      chk("t2b_wr_second", 64'(wc), 64'(5));

      // zero-wait read
      bk_rdy = 0; bk_dly = 0; bk_resp = OKAY; bk_rdata = 32'h1234;
      rd_addr = 32'h4;
      exp_cmd.push_back(mk_cmd(1'b0, 32'h4, 32'h0, 4'h0));
      exp_cpl.push_back(mk_cpl(1'b0, OKAY, 32'h1234));
      rd_req = 1'b1;
      serve(40, wc, rc);
      chk("t3_rd_lat", 64'(rc), 64'(2));

      // silent backend: timeout after 16 cycles in ISSUE/WAIT
      bk_auto = 1'b0;
      be_ready = 1'b0;
      be_done = 1'b0;
      rd_addr = 32'h20;
      exp_cpl.push_back(mk_cpl(1'b0, SLVERR, 32'h0));
      rd_req = 1'b1;
      serve(60, wc, rc);
      chk("t4_tmo_cycle", 64'(rc), 64'(17));
      chk("t4_valid_dropped", 64'(be_valid), 64'(0));
      repeat (2) @(posedge ACLK);
      #1;
      be_done = 1'b1;
      be_resp = OKAY;
      be_rdata = 32'hBAD0BAD0;
      @(posedge ACLK);
      #1;
      be_done = 1'b0;
      repeat (4) @(posedge ACLK);
      #1;
      chk("t4_no_late_cpl", 64'(exp_cpl.size()), 64'(0));
      bk_auto = 1'b1;

      // reset while waiting on the backend
      bk_rdy = 0; bk_dly = 10; bk_resp = OKAY;
      wr_addr = 32'h40; wr_wdata = 32'h0BADF00D; wr_wstrb = 4'hC;
      exp_cmd.push_back(mk_cmd(1'b1, 32'h40, 32'h0BADF00D, 4'hC));
      wr_req = 1'b1;
      repeat (4) @(posedge ACLK);
      #1;
      chk("t5_in_wait_valid", 64'(be_valid), 64'(0));
      chk("t5_in_wait_write", 64'(be_write), 64'(1));
      ARESET = 1'b1;
      wr_req = 1'b0;
      @(posedge ACLK);
      #1;
      chk_zero("t5_rst");
      ARESET = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      bk_rdy = 0; bk_dly = 0; bk_rdata = 32'h77;
      wr_addr = 32'h44; wr_wdata = 32'h12345678; wr_wstrb = 4'hF;
      rd_addr = 32'h48;
      exp_cmd.push_back(mk_cmd(1'b1, 32'h44, 32'h12345678, 4'hF));
      exp_cmd.push_back(mk_cmd(1'b0, 32'h48, 32'h0, 4'h0));
      exp_cpl.push_back(mk_cpl(1'b1, OKAY, 32'h0));
      exp_cpl.push_back(mk_cpl(1'b0, OKAY, 32'h77));
      wr_req = 1'b1;
      rd_req = 1'b1;
      serve(40, wc, rc);
      chk("t5_wr_first", 64'(wc), 64'(2));
      chk("t5_rd_second", 64'(rc), 64'(5));

      // DECERR write with request fields changing in flight
      bk_rdy = 1; bk_dly = 4; bk_resp = DECERR; bk_rdata = 32'hFFFF;
      wr_addr = 32'h80; wr_wdata = 32'hA5A5A5A5; wr_wstrb = 4'h5;
      exp_cmd.push_back(mk_cmd(1'b1, 32'h80, 32'hA5A5A5A5, 4'h5));
      exp_cpl.push_back(mk_cpl(1'b1, DECERR, 32'h0));
      wr_req = 1'b1;
      fork
         serve(40, wc, rc);
         begin
            repeat (5) begin
               @(posedge ACLK);
               #2;
               wr_addr = wr_addr ^ 32'hFF00;
               wr_wdata = ~wr_wdata;
               wr_wstrb = ~wr_wstrb;
            end
         end
      join
      chk("t6_wr_cycle", 64'(wc), 64'(6));

      repeat (3) @(posedge ACLK);
      #1;
      chk("end_cpl_empty", 64'(exp_cpl.size()), 64'(0));
      chk("end_cmd_empty", 64'(exp_cmd.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
